// File: rtl/alu_sequencer.sv
// Sequences one request through an external combinational ALU, repeating
// shift/rotate operations and updating the PSW once from the final iteration.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_sel,
  input  logic [1:0]  req_func,
  input  logic        req_byte,
  input  logic [3:0]  req_count,
  input  logic [3:0]  req_mask,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [1:0]  alu_block_sel,
  output logic [1:0]  alu_block_func,
  output logic        alu_byte_op,
  output logic        alu_carry_in,
  output logic [15:0] alu_src_a,
  output logic [15:0] alu_src_b,
  input  logic [15:0] alu_result,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic        alu_ovf,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        psw_c,
  output logic        psw_z,
  output logic        psw_n,
  output logic        psw_v,
  input  logic        psw_wr_en,
  input  logic [3:0]  psw_wr_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  sel_q, func_q;
  logic        byte_q;
  logic [3:0]  mask_q;
  logic [15:0] a_q, b_q;
  logic        carry_q;
  logic [3:0]  remaining_q;

  logic accept, iterate, step, finish;

  // Only SRA/RRC repeat; other shifter functions complete in one pass.
  assign iterate = (sel_q == 2'd2) && !func_q[1] && (remaining_q > 4'd1);
  assign accept  = (state == IDLE) && req_valid;
  assign step    = (state == EXEC) && iterate;
  assign finish  = (state == EXEC) && !iterate;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = EXEC;
      EXEC:    if (!iterate)  state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs depend on state only: no rsp_ready -> req_ready path.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q       <= 2'd0;
      func_q      <= 2'd0;
      byte_q      <= 1'b0;
      mask_q      <= 4'd0;
      a_q         <= 16'd0;
      b_q         <= 16'd0;
      carry_q     <= 1'b0;
      remaining_q <= 4'd0;
      rsp_result  <= 16'd0;
    end else begin
      if (accept) begin
        sel_q       <= req_sel;
        func_q      <= req_func;
        byte_q      <= req_byte;
        mask_q      <= req_mask;
        a_q         <= req_a;
        b_q         <= req_b;
        carry_q     <= psw_c;
        remaining_q <= (req_count == 4'd0) ? 4'd1 : req_count;
      end else if (step) begin
        a_q         <= alu_result;
        carry_q     <= alu_carry;
        remaining_q <= remaining_q - 4'd1;
      end
      if (finish) rsp_result <= alu_result;
    end
  end

  // A direct PSW load overrides the completion update on all four bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      {psw_v, psw_n, psw_z, psw_c} <= 4'd0;
    end else if (psw_wr_en) begin
      {psw_v, psw_n, psw_z, psw_c} <= psw_wr_data;
    end else if (finish) begin
      if (mask_q[3]) psw_v <= alu_ovf;
      if (mask_q[2]) psw_n <= alu_neg;
      if (mask_q[1]) psw_z <= alu_zero;
      if (mask_q[0]) psw_c <= alu_carry;
    end
  end

  assign alu_block_sel  = sel_q;
  assign alu_block_func = func_q;
  assign alu_byte_op    = byte_q;
  assign alu_carry_in   = carry_q;
  assign alu_src_a      = a_q;
  assign alu_src_b      = b_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU stands in for the
// external datapath; table vectors use a scoreboard, corner cases are scripted.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_sel, req_func;
  logic        req_byte;
  logic [3:0]  req_count, req_mask;
  logic [15:0] req_a, req_b;
  logic [1:0]  alu_block_sel, alu_block_func;
  logic        alu_byte_op, alu_carry_in;
  logic [15:0] alu_src_a, alu_src_b, alu_result;
  logic        alu_carry, alu_zero, alu_neg, alu_ovf;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic        psw_c, psw_z, psw_n, psw_v;
  logic        psw_wr_en;
  logic [3:0]  psw_wr_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_func(req_func), .req_byte(req_byte),
    .req_count(req_count), .req_mask(req_mask), .req_a(req_a), .req_b(req_b),
    .alu_block_sel(alu_block_sel), .alu_block_func(alu_block_func),
    .alu_byte_op(alu_byte_op), .alu_carry_in(alu_carry_in),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_neg(alu_neg), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .psw_c(psw_c), .psw_z(psw_z), .psw_n(psw_n), .psw_v(psw_v),
    .psw_wr_en(psw_wr_en), .psw_wr_data(psw_wr_data), .busy(busy)
  );

  // Behavioural ALU: arith ADD/ADC/SUB/SBC, logic AND/OR/XOR/NOT,
  // shifter SRA/RRC/SLL/SRL (one bit), move B. Carry on subtract = no borrow.
  logic [15:0] m_bop, m_res;
  logic [16:0] m_sum;
  logic        m_cin, m_c, m_v;

  always_comb begin
    m_bop = alu_block_func[1] ? ~alu_src_b : alu_src_b;
    m_cin = alu_block_func[0] ? alu_carry_in : alu_block_func[1];
    m_sum = {1'b0, alu_src_a} + {1'b0, m_bop} + {16'd0, m_cin};
    m_res = 16'd0;
    m_c   = 1'b0;
    m_v   = 1'b0;
    case (alu_block_sel)
      2'd0: begin
        m_res = m_sum[15:0];
        m_c   = m_sum[16];
        m_v   = (alu_src_a[15] == m_bop[15]) && (m_sum[15] != alu_src_a[15]);
      end
      2'd1: case (alu_block_func)
        2'd0:    m_res = alu_src_a & alu_src_b;
        2'd1:    m_res = alu_src_a | alu_src_b;
        2'd2:    m_res = alu_src_a ^ alu_src_b;
        default: m_res = ~alu_src_a;
      endcase
      2'd2: case (alu_block_func)
        2'd0:    begin m_res = {alu_src_a[15], alu_src_a[15:1]}; m_c = alu_src_a[0];  end
        2'd1:    begin m_res = {alu_carry_in, alu_src_a[15:1]};  m_c = alu_src_a[0];  end
        2'd2:    begin m_res = {alu_src_a[14:0], 1'b0};          m_c = alu_src_a[15]; end
        default: begin m_res = {1'b0, alu_src_a[15:1]};          m_c = alu_src_a[0];  end
      endcase
      default: m_res = alu_src_b;
    endcase
  end

  assign alu_result = m_res;
  assign alu_carry  = m_c;
  assign alu_ovf    = m_v;
  assign alu_zero   = (m_res == 16'd0);
  assign alu_neg    = m_res[15];

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  func;
    logic        byt;
    logic [3:0]  count;
    logic [3:0]  mask;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  psw_init;
    logic [15:0] exp_result;
    logic [3:0]  exp_psw;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [15:0] result;
    logic [3:0]  psw;
    int          lat;
  } exp_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];
  exp_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] psw();
    return {psw_v, psw_n, psw_z, psw_c};
  endfunction

  task automatic scramble_req();
    req_sel   = 2'($urandom());
    req_func  = 2'($urandom());
    req_byte  = 1'($urandom());
    req_count = 4'($urandom());
    req_mask  = 4'($urandom());
    req_a     = 16'($urandom());
    req_b     = 16'($urandom());
  endtask

  task automatic drive_req(input logic [1:0] sel, input logic [1:0] func, input logic byt,
                           input logic [3:0] count, input logic [3:0] mask,
                           input logic [15:0] a, input logic [15:0] b);
    req_valid = 1'b1;
    req_sel   = sel;
    req_func  = func;
    req_byte  = byt;
    req_count = count;
    req_mask  = mask;
    req_a     = a;
    req_b     = b;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Entered and left at 1ns after a rising edge.
  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int   lat;
    bit   seen;
    psw_wr_en   = 1'b1;
    psw_wr_data = v.psw_init;
    @(posedge clk); #1 psw_wr_en = 1'b0;
    drive_req(v.sel, v.func, v.byt, v.count, v.mask, v.a, v.b);
    @(negedge clk);
    check($sformatf("v%0d_req_ready", idx), 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    sb.push_back('{v.exp_result, v.exp_psw, v.exp_lat});
    req_valid = 1'b0;
    scramble_req();
    @(negedge clk);
    check($sformatf("v%0d_alu_ctrl", idx),
          32'({alu_block_sel, alu_block_func, alu_byte_op}),
          32'({v.sel, v.func, v.byt}));
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (rsp_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    e = sb.pop_front();
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(e.lat));
    check($sformatf("v%0d_result", idx), 32'(rsp_result), 32'(e.result));
    check($sformatf("v%0d_psw", idx), 32'(psw()), 32'(e.psw));
    if (!seen) begin
      @(posedge clk); #1;
      pulse_reset();
    end else begin
      rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
    end
  endtask

  task automatic seq_backpressure();
    drive_req(2'd0, 2'd0, 1'b0, 4'd0, 4'hF, 16'h007F, 16'h007F);
    @(posedge clk); #1;
    // A second request is held pending; it must wait until IDLE.
    drive_req(2'd0, 2'd0, 1'b0, 4'd0, 4'h0, 16'h0001, 16'h0001);
    psw_wr_en   = 1'b1;
    psw_wr_data = 4'hA;
    @(posedge clk); #1 psw_wr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_%0d", i), 32'({rsp_valid, req_ready, rsp_result}),
            32'({1'b1, 1'b0, 16'h00FE}));
    end
    check("bp_psw_wr_wins", 32'(psw()), 32'hA);
    rsp_ready = 1'b1;
    #1 check("bp_no_comb_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_idle_after_done", 32'({req_ready, rsp_valid}), 32'({1'b1, 1'b0}));
    check("bp_result_retained", 32'(rsp_result), 32'h00FE);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("b2b_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("b2b_done", 32'({rsp_valid, rsp_result}), 32'({1'b1, 16'h0002}));
    check("b2b_psw_masked", 32'(psw()), 32'hA);
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic seq_reset_mid_shift();
    bit valid_seen;
    psw_wr_en   = 1'b1;
    psw_wr_data = 4'hF;
    @(posedge clk); #1 psw_wr_en = 1'b0;
    drive_req(2'd2, 2'd0, 1'b0, 4'd8, 4'hF, 16'h8000, 16'h0000);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("rs_busy_exec", 32'(busy), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rs_idle", 32'({req_ready, busy, rsp_valid}), 32'({1'b1, 1'b0, 1'b0}));
    check("rs_psw_cleared", 32'(psw()), 32'h0);
    check("rs_result_cleared", 32'(rsp_result), 32'h0);
    valid_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) valid_seen = 1'b1;
    end
    check("rs_no_response", 32'(valid_seen), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    rsp_ready   = 1'b0;
    psw_wr_en   = 1'b1;
    psw_wr_data = 4'hF;
    scramble_req();

    //           sel   func  byt   cnt   mask  A         B         psw0  result    psw   lat
    vecs[0]  = '{2'd0, 2'd0, 1'b0, 4'd0, 4'hF, 16'h007F, 16'h007F, 4'h0, 16'h00FE, 4'h0, 1};
    vecs[1]  = '{2'd0, 2'd2, 1'b0, 4'd0, 4'hF, 16'h007F, 16'h007F, 4'h0, 16'h0000, 4'h3, 1};
    vecs[2]  = '{2'd2, 2'd0, 1'b0, 4'd4, 4'hF, 16'h8000, 16'h0000, 4'h0, 16'hF800, 4'h4, 4};
    vecs[3]  = '{2'd2, 2'd1, 1'b0, 4'd1, 4'h1, 16'h0001, 16'h0000, 4'h1, 16'h8000, 4'h1, 1};
    vecs[4]  = '{2'd2, 2'd1, 1'b1, 4'd3, 4'h1, 16'h0006, 16'h0000, 4'hE, 16'h8000, 4'hF, 3};
    vecs[5]  = '{2'd2, 2'd0, 1'b0, 4'd0, 4'hF, 16'h0004, 16'h0000, 4'h0, 16'h0002, 4'h0, 1};
    vecs[6]  = '{2'd1, 2'd0, 1'b1, 4'd5, 4'hF, 16'hF0F0, 16'hFF00, 4'h0, 16'hF000, 4'h4, 1};
    vecs[7]  = '{2'd0, 2'd0, 1'b0, 4'd0, 4'h0, 16'h8000, 16'h8000, 4'h5, 16'h0000, 4'h5, 1};
    vecs[8]  = '{2'd0, 2'd0, 1'b0, 4'd0, 4'hF, 16'h8000, 16'h8000, 4'h0, 16'h0000, 4'hB, 1};
    vecs[9]  = '{2'd2, 2'd2, 1'b0, 4'd4, 4'hF, 16'h8001, 16'h0000, 4'h0, 16'h0002, 4'h1, 1};
    vecs[10] = '{2'd3, 2'd0, 1'b0, 4'd0, 4'hF, 16'h0000, 16'h1234, 4'hF, 16'h1234, 4'h0, 1};
    vecs[11] = '{2'd0, 2'd1, 1'b0, 4'd0, 4'hF, 16'hFFFF, 16'h0000, 4'h1, 16'h0000, 4'h3, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_handshake", 32'({req_ready, rsp_valid, busy}), 32'({1'b1, 1'b0, 1'b0}));
    check("rst_result", 32'(rsp_result), 32'h0);
    check("rst_psw_over_wr", 32'(psw()), 32'h0);
    check("rst_alu_ctrl", 32'({alu_block_sel, alu_block_func, alu_byte_op, alu_carry_in}), 32'h0);
    check("rst_operands", {alu_src_a, alu_src_b}, 32'h0);
    @(posedge clk); #1;
    rst       = 1'b0;
    psw_wr_en = 1'b0;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);
    seq_backpressure();
    seq_reset_mid_shift();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Ports SHALL be as listed below (name, direction, width, meaning), clock and reset first.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  operation request present.
- req_ready  out  1  sequencer can accept a request.
- req_sel  in  2  ALU block select (0 arith, 1 logic, 2 shifter, 3 move).
- req_func  in  2  function within block.
- req_byte  in  1  byte operation.
- req_count  in  4  shift repeat count; 0 treated as 1.
- req_mask  in  4  PSW update enables {V,N,Z,C}.
- req_a  in  16  operand A.
- req_b  in  16  operand B.
- alu_block_sel  out  2  to ALU.
- alu_block_func  out  2  to ALU.
- alu_byte_op  out  1  to ALU.
- alu_carry_in  out  1  to ALU.
- alu_src_a  out  16  to ALU.
- alu_src_b  out  16  to ALU.
- alu_result  in  16  from combinational ALU.
- alu_carry, alu_zero, alu_neg, alu_ovf  in  1 each  ALU flags.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  16  registered final result.
- psw_c, psw_z, psw_n, psw_v  out  1 each  registered status flags.
- psw_wr_en  in  1  direct PSW load.
- psw_wr_data  in  4  {V,N,Z,C} load value.
- busy  out  1  high in any state other than IDLE.
REQ-002 Clock SHALL be clk; reset SHALL be rst, synchronous, active-high.

Function
REQ-003 FSM SHALL have three states: IDLE, EXEC, DONE.
REQ-004 IDLE: req_ready=1; on req_valid, SHALL latch sel, func, byte, mask, A, B, carry reg := psw_c, remaining := max(req_count,1), then go to EXEC.
REQ-005 req_ready SHALL be 0 in EXEC and DONE; requests there are not accepted.
REQ-006 ALU outputs SHALL be driven only from latched registers, never directly from req_* inputs; alu_carry_in = carry reg.
REQ-007 EXEC, iterative case (sel=2, func in {0,1}, remaining>1): op A := alu_result, carry reg := alu_carry, remaining decremented; stay in EXEC.
REQ-008 EXEC, final case (all other conditions): rsp_result := alu_result; for each set mask bit, corresponding PSW flag := ALU flag of this cycle; go to DONE.
REQ-009 Latency: request accepted at edge T; rsp_valid SHALL rise after edge T+n, where n = remaining count for iterative shifts and 1 for all other operations.
REQ-010 DONE: rsp_valid=1, rsp_result stable; on rsp_ready go to IDLE; SHALL hold indefinitely under back-pressure.
REQ-011 In IDLE, rsp_valid SHALL be 0; rsp_result SHALL retain its last value.
REQ-012 PSW SHALL update at most once per operation, from final-iteration flags only.
REQ-013 psw_wr_en SHALL load PSW from psw_wr_data in any state; if it coincides with the REQ-008 update, psw_wr_en SHALL win for all four bits.
REQ-014 Carry for RRC iterations SHALL chain internally; PSW carry is not modified until completion.
REQ-015 Back-to-back: a request presented in the cycle after DONE→IDLE SHALL be accepted; no combinational path rsp_ready→req_ready.

Reset
REQ-016 rst SHALL force IDLE, rsp_valid=0, rsp_result=0, all PSW flags=0, carry reg=0, remaining=0, ALU control outputs=0, operands=0.
REQ-017 rst asserted mid-EXEC or mid-DONE SHALL abort the operation with no PSW update and no response.
REQ-018 rst SHALL take priority over psw_wr_en.

Verification
REQ-019 ADD: sel0 func0 A=0x007F B=0x007F mask=0xF -> rsp_result=0x00FE, C=Z=N=V=0, rsp_valid two edges after acceptance.
REQ-020 SUB: sel0 func2 A=B=0x007F mask=0xF -> result 0x0000, Z=1, C=1.
REQ-021 SRA ×4: sel2 func0 A=0x8000 count=4 -> result 0xF800, N=1, rsp_valid five edges after acceptance.
REQ-022 RRC chain: psw_wr_data=0x1 loaded, then sel2 func1 A=0x0001 count=1 mask=0x1 -> result 0x8000, psw_c=1, other flags unchanged.
REQ-023 Back-pressure plus conflict: rsp_ready held low 10 cycles -> rsp_valid and rsp_result stable, req_ready=0; psw_wr_en on the completion cycle -> PSW = psw_wr_data.
REQ-024 Reset mid-shift: count=8, rst in third EXEC cycle -> next cycle IDLE, PSW=0, rsp_valid never asserts.
